// File: rtl/pb_edge_capture_pio_pkg.sv
// Shared definitions for the pushbutton edge-capture input PIO.
package pb_edge_capture_pio_pkg;

    // Word addresses of the slave registers
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RESERVED = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

endpackage

// File: rtl/pb_debounce_bit.sv
// One input line: two-flop synchroniser followed by a hold-time debouncer.
// A new level is accepted only after it has been seen on the synchronised
// line for DEBOUNCE_CYCLES consecutive clocks; shorter glitches are dropped.
module pb_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic stable_out
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: shift the synchroniser, count disagreement, accept when the count expires
    always_comb begin
        sync1_d  = raw_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State flops; reset discards any partial count and presets the idle level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= RESET_LEVEL;
            sync2_q  <= RESET_LEVEL;
            stable_q <= RESET_LEVEL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_out = stable_q;

endmodule

// File: rtl/pb_edge_capture_pio.sv
// Avalon-MM input PIO: debounced pushbutton lines, sticky edge capture and
// a masked level interrupt. Reads are zero-latency and ignore chipselect.
module pb_edge_capture_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_POL        = 0,
    parameter bit RESET_LEVEL     = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    import pb_edge_capture_pio_pkg::*;

    logic [WIDTH-1:0] stable_vec;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             wr_en;
    logic             unused_wdata;

    // Only the low WIDTH bits of writedata carry meaning
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect && !write_n;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pb_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_debounce (
            .clk        (clk),
            .reset      (reset),
            .raw_in     (in_port[i]),
            .stable_out (stable_vec[i])
        );
    end

    // Edge detect on the debounced level, polarity chosen at elaboration
    always_comb begin
        if (EDGE_POL != 0) begin
            edge_vec = ~prev_q & stable_vec;
        end else begin
            edge_vec = prev_q & ~stable_vec;
        end
    end

    // Register writes; a new edge beats a simultaneous clear of the same bit
    always_comb begin
        prev_d  = stable_vec;
        mask_d  = mask_q;
        cap_clr = '0;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_EDGECAP)) begin
            cap_clr = writedata[WIDTH-1:0];
        end
        cap_d = (cap_q & ~cap_clr) | edge_vec;
    end

    // Register flops; prev starts at the reset level so release makes no edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= {WIDTH{RESET_LEVEL}};
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            prev_q <= prev_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    // Zero-latency read mux, zero-extended to the bus width
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = stable_vec;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = mask_q;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = cap_q;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_pb_edge_capture_pio.sv
// Self-checking bench for pb_edge_capture_pio (WIDTH=4, DEBOUNCE_CYCLES=4,
// falling-edge capture, reset level 1). Every cycle is compared against a
// history-based reference model; table and hand-written vectors also carry
// explicit expected values for the documented corner cases.
module tb_pb_edge_capture_pio;

    localparam int WIDTH = 4;
    localparam int DEB   = 4;
    localparam int HIST  = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  in_port = 4'hF;
    logic [31:0] readdata;
    logic        irq;

    pb_edge_capture_pio #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB),
        .EDGE_POL        (0),
        .RESET_LEVEL     (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [3:0]  inp;
        logic        chk;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: the raw input history drives everything. A bit's
    // debounced level flips once the synchronised input (raw delayed two
    // clocks) has shown the opposite level on DEB consecutive clocks since
    // the last flip or reset release.
    logic [3:0] in_hist [0:HIST-1];
    logic [3:0] m_stable, m_prev, m_cap, m_mask;
    int         n_edge = 0;
    int         r_edge = 0;
    int         last_flip [4];
    logic       in_reset = 1'b1;

    function automatic logic [3:0] sync_at(input int j);
        if (j - 2 >= r_edge) return in_hist[j-2];
        return 4'hF;
    endfunction

    task automatic model_reset();
        m_stable = 4'hF;
        m_prev   = 4'hF;
        m_cap    = 4'h0;
        m_mask   = 4'h0;
    endtask

    task automatic model_release();
        r_edge = n_edge;
        for (int b = 0; b < 4; b++) last_flip[b] = n_edge - 1;
    endtask

    task automatic model_update();
        logic [3:0] new_st;
        logic [3:0] edges;
        logic [3:0] clr;
        logic [3:0] s;
        logic       ok;
        new_st = m_stable;
        edges  = m_prev & ~m_stable;
        in_hist[n_edge] = in_port;
        for (int b = 0; b < 4; b++) begin
            if (n_edge - DEB + 1 > last_flip[b]) begin
                ok = 1'b1;
                for (int j = n_edge - DEB + 1; j <= n_edge; j++) begin
                    s = sync_at(j);
                    if (s[b] == m_stable[b]) ok = 1'b0;
                end
                if (ok) begin
                    new_st[b]    = ~m_stable[b];
                    last_flip[b] = n_edge;
                end
            end
        end
        clr = 4'h0;
        if (chipselect && !write_n && address == 2'd3) clr = writedata[3:0];
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[3:0];
        m_cap    = (m_cap & ~clr) | edges;
        m_prev   = m_stable;
        m_stable = new_st;
        n_edge++;
    endtask

    function automatic logic [31:0] model_rd();
        case (address)
            2'd0:    return {28'd0, m_stable};
            2'd2:    return {28'd0, m_mask};
            2'd3:    return {28'd0, m_cap};
            default: return 32'd0;
        endcase
    endfunction

    function automatic vec_t mk(input logic rst, input logic [1:0] addr, input logic cs,
                                input logic wn, input logic [31:0] wd, input logic [3:0] inp,
                                input logic chk, input logic [31:0] exp_rd, input logic exp_irq);
        vec_t v;
        v.rst = rst; v.addr = addr; v.cs = cs; v.wn = wn; v.wd = wd; v.inp = inp;
        v.chk = chk; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
        return v;
    endfunction

    task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, want 0x%08h", nm, $time, act, exp);
        end
    endtask

    // Drive one bus/input cycle at the falling edge, compare shortly after,
    // then let the model follow the rising edge.
    task automatic apply_stimulus(input vec_t v, input string tag);
        @(negedge clk);
        reset      = v.rst;
        address    = v.addr;
        chipselect = v.cs;
        write_n    = v.wn;
        writedata  = v.wd;
        in_port    = v.inp;
        if (v.rst) model_reset();
        else if (in_reset) model_release();
        in_reset = v.rst;
        #1;
        check_output({tag, " model_rd"}, readdata, model_rd());
        check_output({tag, " model_irq"}, {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
        if (v.chk) begin
            check_output({tag, " vec_rd"}, readdata, v.exp_rd);
            check_output({tag, " vec_irq"}, {31'd0, irq}, {31'd0, v.exp_irq});
        end
        @(posedge clk);
        if (!v.rst) model_update();
    endtask

    vec_t tbl[$];

    initial begin
        logic [3:0] cur_in;
        logic [3:0] flipm;
        vec_t       v;
        model_reset();

        // Reset, idle readback, debounce latency, mask/irq and clear behaviour
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'hF, 1, 32'hF, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'hF, 1, 32'hF, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 4'hF, 1, 32'hF, 0));
        tbl.push_back(mk(0, 3, 0, 1, 0, 4'hF, 1, 32'h0, 0));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 0, 0, 1, 0, 4'hE, 1, 32'hF, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 4'hE, 1, 32'hE, 0));
        tbl.push_back(mk(0, 3, 0, 1, 0, 4'hE, 1, 32'h1, 0));
        tbl.push_back(mk(0, 2, 1, 0, 32'h1, 4'hE, 1, 32'h0, 0));
        tbl.push_back(mk(0, 2, 0, 1, 0, 4'hE, 1, 32'h1, 1));
        tbl.push_back(mk(0, 3, 1, 0, 32'h0, 4'hE, 1, 32'h1, 1));
        tbl.push_back(mk(0, 3, 0, 1, 0, 4'hE, 1, 32'h1, 1));
        tbl.push_back(mk(0, 3, 1, 0, 32'h1, 4'hE, 1, 32'h1, 1));
        tbl.push_back(mk(0, 3, 0, 1, 0, 4'hE, 1, 32'h0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'hFFFF_FFFF, 4'hE, 1, 32'hE, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 4'hE, 1, 32'hE, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'hFFFF_FFFF, 4'hE, 1, 32'h0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 4'hE, 1, 32'h0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 32'h0, 4'hE, 1, 32'h1, 0));
        tbl.push_back(mk(0, 2, 0, 1, 0, 4'hE, 1, 32'h1, 0));
        foreach (tbl[i]) apply_stimulus(tbl[i], $sformatf("tbl[%0d]", i));

        // Rising edge on bit 0 is not captured; then a 3-cycle glitch on bit 2
        for (int i = 0; i < 8; i++) apply_stimulus(mk(0, 0, 0, 1, 0, 4'hF, 0, 0, 0), "rise");
        apply_stimulus(mk(0, 0, 0, 1, 0, 4'hF, 1, 32'hF, 0), "rise data");
        apply_stimulus(mk(0, 3, 0, 1, 0, 4'hF, 1, 32'h0, 0), "rise cap");
        for (int i = 0; i < 3; i++) apply_stimulus(mk(0, 0, 0, 1, 0, 4'hB, 1, 32'hF, 0), "glitch low");
        for (int i = 0; i < 8; i++) apply_stimulus(mk(0, 0, 0, 1, 0, 4'hF, 1, 32'hF, 0), "glitch high");
        apply_stimulus(mk(0, 3, 0, 1, 0, 4'hF, 1, 32'h0, 0), "glitch cap");

        // Clear of bit 1 in the very cycle its debounced falling edge latches
        for (int i = 0; i < 6; i++) apply_stimulus(mk(0, 0, 0, 1, 0, 4'hD, 1, 32'hF, 0), "race wait");
        apply_stimulus(mk(0, 3, 1, 0, 32'h2, 4'hD, 1, 32'h0, 0), "race clear");
        apply_stimulus(mk(0, 3, 0, 1, 0, 4'hD, 1, 32'h2, 0), "race result");

        // Pending irq, partial debounce, then reset; release debounces the zeros in
        apply_stimulus(mk(0, 2, 1, 0, 32'hF, 4'hD, 1, 32'h1, 0), "mask all");
        apply_stimulus(mk(0, 3, 0, 1, 0, 4'hD, 1, 32'h2, 1), "irq pending");
        for (int i = 0; i < 3; i++) apply_stimulus(mk(0, 3, 0, 1, 0, 4'h0, 1, 32'h2, 1), "partial");
        apply_stimulus(mk(1, 3, 0, 1, 0, 4'h0, 1, 32'h0, 0), "reset irq drop");
        apply_stimulus(mk(1, 2, 0, 1, 0, 4'h0, 1, 32'h0, 0), "reset mask");
        for (int i = 0; i < 6; i++) apply_stimulus(mk(0, 0, 0, 1, 0, 4'h0, 1, 32'hF, 0), "post reset");
        apply_stimulus(mk(0, 0, 0, 1, 0, 4'h0, 1, 32'h0, 0), "post data");
        apply_stimulus(mk(0, 3, 0, 1, 0, 4'h0, 1, 32'hF, 0), "post cap");
        apply_stimulus(mk(0, 2, 0, 1, 0, 4'h0, 1, 32'h0, 0), "post mask");

        // Randomized traffic: slowly changing inputs, random bus accesses, rare resets
        cur_in = 4'h0;
        for (int k = 0; k < 600; k++) begin
            flipm = 4'h0;
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) flipm[b] = 1'b1;
            cur_in = cur_in ^ flipm;
            v = mk(($urandom_range(0, 99) == 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 2) != 0), $urandom, cur_in, 0, 0, 0);
            apply_stimulus(v, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
